// File: rtl/sysarr_tile_sequencer.sv
// Tile sequencer: streams weight/input/partial rows into the systolic array
// and buffers its output rows in a small result FIFO for downstream.
module sysarr_tile_sequencer #(
  parameter int DW = 16,
  parameter int N  = 4
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    reuse_weights,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [DW*N-1:0]         src_data,
  input  logic [DW*N-1:0]         src_psum,
  output logic                    weight_en,
  output logic                    input_en,
  output logic                    partial_en,
  output logic [$clog2(N)-1:0]    row_in_en,
  output logic [$clog2(N)-1:0]    row_ps_en,
  output logic [DW*N-1:0]         array_in,
  output logic [DW*N-1:0]         array_in_partials,
  input  logic                    fifo_has_space,
  input  logic                    out_en,
  input  logic [$clog2(N)-1:0]    row_out,
  input  logic [DW*N-1:0]         array_output,
  input  logic                    drained,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(N)-1:0]    res_row,
  output logic [DW*N-1:0]         res_data
);

  localparam int KW = $clog2(N);
  localparam int W  = DW * N;
  localparam logic [KW:0]   NFULL = (KW+1)'(N);
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, WEIGHT, STREAM, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0] k;
  logic [KW:0]   collected;
  logic [KW:0]   count;
  logic [KW-1:0] wr_ptr, rd_ptr;
  logic [KW-1:0] mem_row  [N];
  logic [W-1:0]  mem_data [N];

  logic hs, last, start_ok;
  logic push, pop, full, drop;
  logic stream_en, row_en;

  assign src_ready = (state == WEIGHT) ||
                     ((state == STREAM) && fifo_has_space);
  assign hs        = src_valid && src_ready;
  assign last      = (k == KLAST);
  assign start_ok  = (state == IDLE) && start;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = reuse_weights ? STREAM : WEIGHT;
      WEIGHT:  if (hs && last) state_nx = STREAM;
      STREAM:  if (hs && last) state_nx = DRAIN;
      DRAIN:   if (drained && collected == NFULL && count == '0)
                 state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Row counter restarts at every phase boundary.
  always_ff @(posedge clk or posedge RST) begin
    if (RST)                    k <= '0;
    else if (state != state_nx) k <= '0;
    else if (hs)                k <= k + 1'b1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST)                                collected <= '0;
    else if (start_ok)                      collected <= '0;
    else if (out_en && collected != NFULL) collected <= collected + 1'b1;
  end

  assign full = (count == NFULL);
  assign pop  = res_valid && res_ready;
  assign push = out_en && (!full || pop);
  assign drop = out_en && full && !pop;

  // A dropped row in the same cycle as a start still leaves a mark.
  always_ff @(posedge clk or posedge RST) begin
    if (RST)           overflow <= 1'b0;
    else if (drop)     overflow <= 1'b1;
    else if (start_ok) overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_row[wr_ptr]  <= row_out;
      mem_data[wr_ptr] <= array_output;
    end
  end

  assign res_valid = (count != '0);
  assign res_row   = res_valid ? mem_row[rd_ptr]  : '0;
  assign res_data  = res_valid ? mem_data[rd_ptr] : '0;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign weight_en  = (state == WEIGHT) && hs;
  assign stream_en  = (state == STREAM) && hs;
  assign input_en   = stream_en;
  assign partial_en = stream_en;
  assign row_en     = weight_en || stream_en;

  assign row_in_en         = row_en    ? k        : '0;
  assign row_ps_en         = stream_en ? k        : '0;
  assign array_in          = row_en    ? src_data : '0;
  assign array_in_partials = stream_en ? src_psum : '0;

endmodule

// File: doc/sysarr_tile_sequencer.md
Name: sysarr_tile_sequencer

Overview:
- Memory-side driver for the systolic array's memory interface: the initiator end of the weight/input/partial load protocol, and the consumer of the array's output rows.
- Per tile it takes N weight rows, then N input rows paired with N partial-sum rows, from an upstream ready/valid stream and drives them into the array, honouring fifo_has_space.
- Captures every out_en row into an N-deep result FIFO with ready/valid toward downstream.
- Signals tile completion once drained is high and all N rows have been handed off.

Parameters:
- DW, 16, element width in bits
- N, 4, array dimension (rows/columns); power of two, >=2

Ports:
- clk  in  1  clock
- RST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a tile; ignored unless idle
- reuse_weights  in  1  sampled with start; 1 = skip weight phase
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at tile completion
- overflow  out  1  sticky: out_en arrived while result FIFO full; cleared only by reset or accepted start
- src_valid  in  1  upstream beat valid
- src_ready  out  1  upstream beat accepted when src_valid&&src_ready
- src_data  in  DW*N  weight row (weight phase) or input row (stream phase)
- src_psum  in  DW*N  partial-sum row (stream phase only; ignored otherwise)
- weight_en  out  1  array_in carries a weight row this cycle
- input_en  out  1  array_in carries an input row this cycle
- partial_en  out  1  array_in_partials carries a partial row this cycle
- row_in_en  out  $clog2(N)  row index for weight/input beat
- row_ps_en  out  $clog2(N)  row index for partial beat
- array_in  out  DW*N  row data to array
- array_in_partials  out  DW*N  partial row to array
- fifo_has_space  in  1  array input/partial FIFOs can accept a row
- out_en  in  1  array output row valid (no backpressure)
- row_out  in  $clog2(N)  index of output row
- array_output  in  DW*N  output row data
- drained  in  1  array has no work in flight
- res_valid  out  1  result FIFO head valid
- res_ready  in  1  downstream accepts head
- res_row  out  $clog2(N)  row index of head
- res_data  out  DW*N  data of head

Behaviour:
- Reset: state IDLE, all counters 0, result FIFO empty. Outputs 0: busy, done, overflow, src_ready, weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials, res_valid.
- All array-side outputs are combinational from state/counter and the upstream beat. Every en is asserted only in the cycle of a src handshake, with array_in=src_data and array_in_partials=src_psum. When no en is asserted, data and row outputs are 0.
- Counter k in 0..N-1 counts rows accepted in the current phase; it wraps to 0 on phase change.
- IDLE: start → WEIGHT (reuse_weights=0) or STREAM (reuse_weights=1). An accepted start clears overflow and sets busy from the next cycle.
- WEIGHT: src_ready=1. Each handshake asserts weight_en with row_in_en=k; fifo_has_space is not consulted. After the beat at k=N-1 → STREAM.
- STREAM: src_ready=fifo_has_space. Each handshake asserts input_en and partial_en together, with row_in_en=row_ps_en=k. After the beat at k=N-1 → DRAIN.
- DRAIN: src_ready=0. Leaves for DONE when drained=1, collected==N, and the result FIFO is empty.
- DONE: done=1 for one cycle, busy=0 next cycle → IDLE.
- collected: counts out_en events since the accepted start (saturates at N), including dropped ones. out_en is captured in any state.
- Result FIFO: N entries of {row_out, array_output}. Push on out_en. Pop on res_valid&&res_ready. Push and pop in the same cycle are both legal when full. Push while full without a pop: the entry is dropped and overflow is set. Head is held stable while res_valid&&!res_ready.
- start while busy: ignored, no effect on state or flags.
- src_valid with src_ready=0: nothing is driven to the array, the counter holds.
- RST asserted mid-tile: immediate return to reset values. Partial array state is not flushed by this block.

Test Plan:
- N=4, reuse_weights=0, src_valid always 1, fifo_has_space=1 → weight_en high 4 consecutive cycles with row_in_en 0,1,2,3, then input_en&&partial_en for 4 cycles with rows 0..3.
- fifo_has_space low for 3 cycles during STREAM at k=2 → src_ready=0 and no en for those 3 cycles; row 2 is issued the cycle space returns; total stream beats still 4.
- reuse_weights=1 → weight_en never asserts; the first beat after start is input_en with row 0.
- Model array asserts out_en rows 0..3 with res_ready=1, then drained=1 → 4 results in order with matching data; done pulses once; busy falls the next cycle.
- res_ready=0 and 5 out_en pulses → 4 entries held, overflow=1, 5th dropped. The next accepted start clears overflow.
- RST asserted in DRAIN with 2 results queued → all outputs 0 and res_valid=0 immediately; start afterwards begins a fresh tile at WEIGHT row 0.
